// File: rtl/abs_diff_pkg.sv
// Shared types and helpers for the absolute-difference pipeline with
// runtime exact/approximate mode.
package abs_diff_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Mask of the LSBs that are forced to zero in approximate mode,
    // clamped to the operand width.
    function automatic logic [31:0] trunc_mask(input int unsigned width,
                                               input int unsigned trunc_bits);
        int unsigned n;
        if (trunc_bits < width) begin
            n = trunc_bits;
        end else begin
            n = width;
        end
        if (n >= 32) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << n) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/abs_diff_core.sv
// Combinational |(a & ~mask) - (b & ~mask)| for unsigned operands.
module abs_diff_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_diff
);

    logic [WIDTH-1:0] w_a_m;
    logic [WIDTH-1:0] w_b_m;

    assign w_a_m = i_a & ~i_mask;
    assign w_b_m = i_b & ~i_mask;

    // Subtract the smaller masked operand from the larger one.
    always_comb begin
        o_diff = {WIDTH{1'b0}};
        if (w_a_m >= w_b_m) begin
            o_diff = w_a_m - w_b_m;
        end else begin
            o_diff = w_b_m - w_a_m;
        end
    end

endmodule

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage valid/ready |a-b| pipeline with exact/approximate mode and an
// on-line monitor that tracks the approximation error against ET.
module abs_diff_approx_pipe
    import abs_diff_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TRUNC_BITS = 2,
    parameter int ET         = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic [WIDTH-1:0] out_err,
    input  logic             stat_clr,
    output logic [WIDTH-1:0] max_err,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic             et_flag
);

    localparam logic [WIDTH-1:0] TRUNC_M = WIDTH'(trunc_mask(WIDTH, TRUNC_BITS));
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_init_done;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    mode_e            r_s1_mode;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_diff;
    logic [WIDTH-1:0] r_out_err;
    logic [WIDTH-1:0] r_max_err;
    logic [CNT_W-1:0] r_viol_cnt;
    logic [CNT_W-1:0] r_smp_cnt;
    logic             r_et_flag;

    logic             w_advance;
    logic             w_in_ready;
    logic             w_out_xfer;
    logic             w_viol;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_exact;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_err;

    assign w_advance  = ~r_out_valid | out_ready;
    assign w_in_ready = r_init_done & (~r_s1_valid | w_advance);
    assign w_out_xfer = r_out_valid & out_ready;
    assign w_viol     = 32'(r_out_err) > 32'(ET);

    // Hold off in_ready for the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    // Stage 1: capture operands and mode on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= {WIDTH{1'b0}};
            r_s1_b     <= {WIDTH{1'b0}};
            r_s1_mode  <= MODE_EXACT;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_mode <= mode_e'(in_mode);
            end
        end
    end

    // Exact mode uses an all-zero mask, so the second core yields the
    // result the sample asked for in either mode.
    always_comb begin
        w_mask = {WIDTH{1'b0}};
        if (r_s1_mode == MODE_APPROX) begin
            w_mask = TRUNC_M;
        end else begin
            w_mask = {WIDTH{1'b0}};
        end
    end

    abs_diff_core #(.WIDTH(WIDTH)) u_core_exact (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .i_mask ({WIDTH{1'b0}}),
        .o_diff (w_exact)
    );

    abs_diff_core #(.WIDTH(WIDTH)) u_core_sel (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .i_mask (w_mask),
        .o_diff (w_sel)
    );

    // The approximation can land on either side of the exact value.
    always_comb begin
        w_err = {WIDTH{1'b0}};
        if (w_exact >= w_sel) begin
            w_err = w_exact - w_sel;
        end else begin
            w_err = w_sel - w_exact;
        end
    end

    // Stage 2: output register, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_diff  <= {WIDTH{1'b0}};
            r_out_err   <= {WIDTH{1'b0}};
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_diff <= w_sel;
                r_out_err  <= w_err;
            end
        end
    end

    // Error monitor; a clear on the same cycle as a transfer drops that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_err  <= {WIDTH{1'b0}};
            r_viol_cnt <= {CNT_W{1'b0}};
            r_smp_cnt  <= {CNT_W{1'b0}};
            r_et_flag  <= 1'b0;
        end else if (stat_clr) begin
            r_max_err  <= {WIDTH{1'b0}};
            r_viol_cnt <= {CNT_W{1'b0}};
            r_smp_cnt  <= {CNT_W{1'b0}};
            r_et_flag  <= 1'b0;
        end else if (w_out_xfer) begin
            if (r_smp_cnt != CNT_MAX) begin
                r_smp_cnt <= r_smp_cnt + CNT_W'(1);
            end
            if (w_viol) begin
                r_et_flag <= 1'b1;
                if (r_viol_cnt != CNT_MAX) begin
                    r_viol_cnt <= r_viol_cnt + CNT_W'(1);
                end
            end
            if (r_out_err > r_max_err) begin
                r_max_err <= r_out_err;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_diff  = r_out_diff;
    assign out_err   = r_out_err;
    assign max_err   = r_max_err;
    assign viol_cnt  = r_viol_cnt;
    assign smp_cnt   = r_smp_cnt;
    assign et_flag   = r_et_flag;

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Randomized and directed bench for abs_diff_approx_pipe against a queue-based reference model.
module tb_abs_diff_approx_pipe;

    localparam int W  = 8;
    localparam int T  = 2;
    localparam int ET = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = 8'd0;
    logic [W-1:0] in_b = 8'd0;
    logic         in_mode = 1'b0;
    logic         out_ready = 1'b0;
    logic         stat_clr = 1'b0;

    logic         in_ready, out_valid, et_flag;
    logic [W-1:0] out_diff, out_err, max_err;
    logic [15:0]  viol_cnt, smp_cnt;

    logic         in_ready4, out_valid4, et_flag4;
    logic [W-1:0] out_diff4, out_err4, max_err4;
    logic [3:0]   viol_cnt4, smp_cnt4;

    always #5 clk = ~clk;

    abs_diff_approx_pipe #(.WIDTH(W), .TRUNC_BITS(T), .ET(ET), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_diff(out_diff), .out_err(out_err),
        .stat_clr(stat_clr), .max_err(max_err), .viol_cnt(viol_cnt),
        .smp_cnt(smp_cnt), .et_flag(et_flag)
    );

    abs_diff_approx_pipe #(.WIDTH(W), .TRUNC_BITS(T), .ET(ET), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_diff(out_diff4), .out_err(out_err4),
        .stat_clr(stat_clr), .max_err(max_err4), .viol_cnt(viol_cnt4),
        .smp_cnt(smp_cnt4), .et_flag(et_flag4)
    );

    typedef struct {
        int diff;
        int err;
        int t_in;
    } exp_t;

    exp_t q[$];
    int   m_cyc = 0;
    int   m_smp = 0, m_viol = 0, m_smp4 = 0, m_viol4 = 0, m_max = 0;
    bit   m_et = 1'b0;
    bit   m_rdy = 1'b0;
    bit   acc_last = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic int absd(input int x, input int y);
        return (x >= y) ? x - y : y - x;
    endfunction

    function automatic int trunc(input int x);
        return x - (x % (1 << T));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_stats();
        m_smp = 0; m_viol = 0; m_smp4 = 0; m_viol4 = 0; m_max = 0; m_et = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit   ihs, ohs, exp_ov;
        exp_t e;
        int   ex, ap;
        @(negedge clk);
        exp_ov = (q.size() > 0) ? (q[0].t_in < m_cyc) : 1'b0;
        check_eq("in_ready", in_ready, m_rdy && (q.size() < 2 || out_ready));
        check_eq("in_ready_c4", in_ready4, m_rdy && (q.size() < 2 || out_ready));
        check_eq("out_valid", out_valid, exp_ov);
        check_eq("out_valid_c4", out_valid4, exp_ov);
        if (exp_ov) begin
            check_eq("out_diff", out_diff, q[0].diff);
            check_eq("out_err", out_err, q[0].err);
            check_eq("out_diff_c4", out_diff4, q[0].diff);
            check_eq("out_err_c4", out_err4, q[0].err);
        end
        check_eq("smp_cnt", smp_cnt, m_smp);
        check_eq("viol_cnt", viol_cnt, m_viol);
        check_eq("max_err", max_err, m_max);
        check_eq("et_flag", et_flag, m_et);
        check_eq("smp_cnt_c4", smp_cnt4, m_smp4);
        check_eq("viol_cnt_c4", viol_cnt4, m_viol4);
        check_eq("max_err_c4", max_err4, m_max);
        check_eq("et_flag_c4", et_flag4, m_et);
        ihs = in_valid && in_ready;
        ohs = out_valid && out_ready && (q.size() > 0);
        @(posedge clk);
        if (rst_n) begin
            m_cyc++;
            if (ohs) begin
                e = q.pop_front();
                if (!stat_clr) begin
                    m_smp  = (m_smp  < 65535) ? m_smp + 1  : m_smp;
                    m_smp4 = (m_smp4 < 15)    ? m_smp4 + 1 : m_smp4;
                    if (e.err > ET) begin
                        m_viol  = (m_viol  < 65535) ? m_viol + 1  : m_viol;
                        m_viol4 = (m_viol4 < 15)    ? m_viol4 + 1 : m_viol4;
                        m_et    = 1'b1;
                    end
                    if (e.err > m_max) m_max = e.err;
                end
            end
            if (stat_clr) clear_stats();
            if (ihs) begin
                ex = absd(int'(in_a), int'(in_b));
                ap = in_mode ? absd(trunc(int'(in_a)), trunc(int'(in_b))) : ex;
                e.diff = ap;
                e.err  = absd(ex, ap);
                e.t_in = m_cyc;
                q.push_back(e);
            end
            m_rdy = 1'b1;
        end
        acc_last = ihs;
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        stat_clr = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_smp_cnt", smp_cnt, 0);
        check_eq("rst_viol_cnt", viol_cnt, 0);
        check_eq("rst_max_err", max_err, 0);
        check_eq("rst_et_flag", et_flag, 0);
        q.delete();
        clear_stats();
        m_rdy = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic send(input int a, input int b, input int m);
        in_a = 8'(a);
        in_b = 8'(b);
        in_mode = 1'(m);
        in_valid = 1'b1;
        acc_last = 1'b0;
        for (int i = 0; i < 50 && !acc_last; i++) cycle();
        in_valid = 1'b0;
        check_eq("send_accept", acc_last, 1);
    endtask

    task automatic drain(input int budget);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && q.size() > 0; i++) cycle();
        check_eq("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx, cnt;
        logic [7:0] bp_a [5];
        logic [7:0] bp_b [5];

        apply_reset();
        cycle();

        // Exact mode: 200 vs 55
        out_ready = 1'b1;
        send(200, 55, 0);
        cycle();
        check_eq("t1_diff", out_diff, 145);
        check_eq("t1_err", out_err, 0);
        cycle();
        check_eq("t1_smp", smp_cnt, 1);
        check_eq("t1_viol", viol_cnt, 0);

        // Approx mode: 7 vs 0 then 9 vs 8
        send(7, 0, 1);
        cycle();
        check_eq("t2_diff", out_diff, 4);
        check_eq("t2_err", out_err, 3);
        cycle();
        check_eq("t2_viol", viol_cnt, 1);
        check_eq("t2_max", max_err, 3);
        check_eq("t2_et", et_flag, 1);
        send(9, 8, 1);
        cycle();
        check_eq("t2b_diff", out_diff, 0);
        check_eq("t2b_err", out_err, 1);
        cycle();
        check_eq("t2b_et", et_flag, 1);
        check_eq("t2b_max", max_err, 3);

        // Backpressure: 6 stalled cycles, only two samples fit
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = 8'($urandom_range(0, 255));
            bp_b[i] = 8'($urandom_range(0, 255));
        end
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = bp_a[idx];
            in_b = bp_b[idx];
            in_mode = idx[0];
            cycle();
            if (acc_last) idx++;
        end
        check_eq("t3_accepts", idx, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && idx < 5; i++) begin
            in_valid = 1'b1;
            in_a = bp_a[idx];
            in_b = bp_b[idx];
            in_mode = idx[0];
            cycle();
            if (acc_last) idx++;
        end
        check_eq("t3_all_sent", idx, 5);
        drain(20);

        // Saturation of the 4-bit counters
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        in_valid = 1'b1;
        in_a = 8'd7;
        in_b = 8'd0;
        in_mode = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 20; i++) begin
            cycle();
            if (acc_last) cnt++;
        end
        in_valid = 1'b0;
        drain(20);
        check_eq("t4_viol4", viol_cnt4, 15);
        check_eq("t4_smp4", smp_cnt4, 15);
        check_eq("t4_viol16", viol_cnt, 20);
        check_eq("t4_smp16", smp_cnt, 20);

        // stat_clr coincident with a violating transfer
        send(7, 0, 1);
        cycle();
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        check_eq("t5_smp", smp_cnt, 0);
        check_eq("t5_viol", viol_cnt, 0);
        check_eq("t5_max", max_err, 0);
        check_eq("t5_et", et_flag, 0);
        check_eq("t5_delivered", q.size(), 0);

        // Reset with two samples in flight
        out_ready = 1'b0;
        send(10, 3, 0);
        send(100, 1, 1);
        apply_reset();
        out_ready = 1'b1;
        repeat (5) cycle();
        check_eq("t6_smp", smp_cnt, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a = 8'($urandom_range(0, 255));
                in_b = 8'($urandom_range(0, 255));
                in_mode = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            stat_clr = ($urandom_range(0, 49) == 0);
            cycle();
        end
        stat_clr = 1'b0;
        drain(20);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
